// File: rtl/rv_pkg.sv
// Shared RV immediate-format codes for the immediate generator.
package rv_pkg;

  localparam int IMM_SRC_W = 3;

  localparam logic [IMM_SRC_W-1:0] IMM_I     = 3'd0;
  localparam logic [IMM_SRC_W-1:0] IMM_S     = 3'd1;
  localparam logic [IMM_SRC_W-1:0] IMM_B     = 3'd2;
  localparam logic [IMM_SRC_W-1:0] IMM_U     = 3'd3;
  localparam logic [IMM_SRC_W-1:0] IMM_J     = 3'd4;
  localparam logic [IMM_SRC_W-1:0] IMM_SHAMT = 3'd5;

endpackage

// File: rtl/imm_gen_pipe_stage.sv
// One valid/ready register slot; accepts whenever empty or draining this cycle.
module imm_gen_pipe_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic          valid,
  output logic [DW-1:0] data,
  input  logic          down_ready
);

  assign up_ready = ~valid | down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with STAGES valid/ready slots.
// Optional feature macro IMM_GEN_ERR_EN: adds imm_err flag for reserved imm_src codes.
module imm_gen_pipe
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      imm_ext
`ifdef IMM_GEN_ERR_EN
  ,
  output logic                 imm_err
`endif
);

  if (!(XLEN == 32 || XLEN == 64) || STAGES < 1 || STAGES > 3) begin : g_bad_param
    $fatal(1, "imm_gen_pipe: XLEN must be 32/64 and STAGES 1..3");
  end

`ifdef IMM_GEN_ERR_EN
  localparam int DW = XLEN + 1;
`else
  localparam int DW = XLEN;
`endif

  function automatic logic [XLEN-1:0] decode(input logic [31:0] i,
                                             input logic [IMM_SRC_W-1:0] s);
    logic [XLEN-1:0] v;
    v = '0;
    case (s)
      IMM_I:     v = XLEN'($signed(i[31:20]));
      IMM_S:     v = XLEN'($signed({i[31:25], i[11:7]}));
      IMM_B:     v = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      IMM_U:     v = XLEN'($signed({i[31:12], 12'b0}));
      IMM_J:     v = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      IMM_SHAMT: v = (XLEN == 64) ? XLEN'(i[25:20]) : XLEN'(i[24:20]);
      default:   v = '0;
    endcase
    return v;
  endfunction

  logic [DW-1:0]     dec_data;
  logic [STAGES-1:0] slot_valid;
  logic [STAGES-1:0] slot_ready;
  logic [DW-1:0]     slot_data [STAGES];

`ifdef IMM_GEN_ERR_EN
  assign dec_data = {(imm_src > IMM_SHAMT), decode(instr, imm_src)};
  assign imm_err  = slot_data[STAGES-1][XLEN];
`else
  assign dec_data = decode(instr, imm_src);
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic          up_v;
    logic [DW-1:0] up_d;
    logic          dn_rdy;

    if (k == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = dec_data;
    end else begin : g_mid
      assign up_v = slot_valid[k-1];
      assign up_d = slot_data[k-1];
    end

    // Readiness ripples back from the output so bubbles collapse under stall.
    if (k == STAGES - 1) begin : g_last
      assign dn_rdy = out_ready;
    end else begin : g_inner
      assign dn_rdy = slot_ready[k+1];
    end

    imm_gen_pipe_stage #(.DW(DW)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_v),
      .up_data    (up_d),
      .up_ready   (slot_ready[k]),
      .valid      (slot_valid[k]),
      .data       (slot_data[k]),
      .down_ready (dn_rdy)
    );
  end

  assign in_ready  = slot_ready[0];
  assign out_valid = slot_valid[STAGES-1];
  assign imm_ext   = slot_data[STAGES-1][XLEN-1:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized self-checking bench: XLEN32/STAGES1 and XLEN64/STAGES3 against a queue-based model.
module tb_imm_gen_pipe;

  localparam int NCYC = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid [2];
  logic        out_ready [2];
  logic [31:0] instr [2];
  logic [2:0]  src [2];

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] imm_ext_a;
  logic [63:0] imm_ext_b;
  logic        err_a, err_b;

  logic        rdy [2];
  logic        ov [2];
  logic        er [2];
  logic [63:0] ext [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready_a),
    .instr     (instr[0]),
    .imm_src   (src[0]),
    .out_valid (out_valid_a),
    .out_ready (out_ready[0]),
    .imm_ext   (imm_ext_a)
`ifdef IMM_GEN_ERR_EN
    ,
    .imm_err   (err_a)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready_b),
    .instr     (instr[1]),
    .imm_src   (src[1]),
    .out_valid (out_valid_b),
    .out_ready (out_ready[1]),
    .imm_ext   (imm_ext_b)
`ifdef IMM_GEN_ERR_EN
    ,
    .imm_err   (err_b)
`endif
  );

`ifndef IMM_GEN_ERR_EN
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  assign rdy[0] = in_ready_a;
  assign rdy[1] = in_ready_b;
  assign ov[0]  = out_valid_a;
  assign ov[1]  = out_valid_b;
  assign er[0]  = err_a;
  assign er[1]  = err_b;
  assign ext[0] = {32'b0, imm_ext_a};
  assign ext[1] = imm_ext_b;

  function automatic int stg(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int xl(input int i);
    return (i == 0) ? 32 : 64;
  endfunction

  // Reference immediates from field weights and arithmetic shifts; bit 64 = reserved flag.
  function automatic logic [64:0] ref_imm(input int xlen, input logic [31:0] ins,
                                          input logic [2:0] s);
    longint v;
    longint si;
    logic   e;
    si = longint'($signed(ins));
    e  = 1'b0;
    case (s)
      3'd0: v = si >>> 20;
      3'd1: v = (si >>> 25) * 32 + longint'(ins[11:7]);
      3'd2: v = (si >>> 31) * 4096 + longint'(ins[7]) * 2048
                + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      3'd3: v = (si >>> 12) * 4096;
      3'd4: v = (si >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      3'd5: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: begin
        v = 0;
        e = 1'b1;
      end
    endcase
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return {e, 64'(v)};
  endfunction

  task automatic check_val(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: accepted items with the edge index at which they reach the output slot.
  logic [64:0] q_val [2][256];
  int          q_rdy [2][256];
  int          wr [2];
  int          rd [2];
  logic        pend [2];
  logic        is_dir [2];
  logic [64:0] cur_exp [2];
  int          diri [2];
  int          acc_cnt [2];
  int          edge_cnt;

  logic [31:0] d_instr [2][6];
  logic [2:0]  d_src [2][6];
  logic [64:0] d_exp [2][6];
  int          d_n [2];

  initial begin
    logic exp_rdy, exp_ov, acc, drn;
    logic [64:0] front;

    d_instr[0][0] = 32'h0050_0313; d_src[0][0] = 3'd0; d_exp[0][0] = 65'h0_0000_0000_0000_0005;
    d_instr[0][1] = 32'h0064_A423; d_src[0][1] = 3'd1; d_exp[0][1] = 65'h0_0000_0000_0000_0008;
    d_instr[0][2] = 32'hFE00_0EE3; d_src[0][2] = 3'd2; d_exp[0][2] = 65'h0_0000_0000_FFFF_FFFC;
    d_instr[0][3] = 32'h1234_52B7; d_src[0][3] = 3'd3; d_exp[0][3] = 65'h0_0000_0000_1234_5000;
    d_instr[0][4] = 32'hFF9F_F0EF; d_src[0][4] = 3'd4; d_exp[0][4] = 65'h0_0000_0000_FFFF_FFF8;
    d_instr[0][5] = 32'hFFFF_FFFF; d_src[0][5] = 3'd6; d_exp[0][5] = 65'h1_0000_0000_0000_0000;
    d_n[0] = 6;
    d_instr[1][0] = 32'hFFF0_0093; d_src[1][0] = 3'd0; d_exp[1][0] = 65'h0_FFFF_FFFF_FFFF_FFFF;
    d_instr[1][1] = 32'h8000_02B7; d_src[1][1] = 3'd3; d_exp[1][1] = 65'h0_FFFF_FFFF_8000_0000;
    d_instr[1][2] = 32'h03F0_1013; d_src[1][2] = 3'd5; d_exp[1][2] = 65'h0_0000_0000_0000_003F;
    d_instr[1][3] = 32'hFFFF_FFFF; d_src[1][3] = 3'd6; d_exp[1][3] = 65'h1_0000_0000_0000_0000;
    d_n[1] = 4;

    edge_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; instr[i] = '0; src[i] = '0;
      wr[i] = 0; rd[i] = 0; pend[i] = 1'b0; is_dir[i] = 1'b0;
      cur_exp[i] = '0; diri[i] = 0; acc_cnt[i] = 0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("rst_ovalid%0d", i), {64'b0, ov[i]}, 65'd0);
      check_val($sformatf("rst_imm%0d", i), {1'b0, ext[i]}, 65'd0);
      check_val($sformatf("rst_ready%0d", i), {64'b0, rdy[i]}, 65'd1);
    end

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);

      if (c == 60) begin
        // Asynchronous reset between edges with traffic in flight.
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
          check_val($sformatf("arst_ovalid%0d", i), {64'b0, ov[i]}, 65'd0);
          check_val($sformatf("arst_imm%0d", i), {1'b0, ext[i]}, 65'd0);
`ifdef IMM_GEN_ERR_EN
          check_val($sformatf("arst_err%0d", i), {64'b0, er[i]}, 65'd0);
`endif
          rd[i] = wr[i]; pend[i] = 1'b0; in_valid[i] = 1'b0; acc_cnt[i] = 0;
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
          check_val($sformatf("post_rst_ready%0d", i), {64'b0, rdy[i]}, 65'd1);
        continue;
      end

      if (c == 67) begin
        for (int i = 0; i < 2; i++)
          check_val($sformatf("stall_accepts%0d", i), 65'(acc_cnt[i]), 65'(stg(i)));
      end

      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          is_dir[i] = 1'b0;
          if (diri[i] < d_n[i]) begin
            in_valid[i] = 1'b1;
            instr[i]    = d_instr[i][diri[i]];
            src[i]      = d_src[i][diri[i]];
            cur_exp[i]  = d_exp[i][diri[i]];
            is_dir[i]   = 1'b1;
          end else begin
            in_valid[i] = (c >= 61 && c <= 74) ? 1'b1 : ($urandom_range(0, 3) != 0);
            instr[i]    = $urandom;
            src[i]      = 3'($urandom_range(0, 7));
            cur_exp[i]  = ref_imm(xl(i), instr[i], src[i]);
          end
        end
        if (diri[i] < d_n[i] || (c >= 67 && c <= 74)) out_ready[i] = 1'b1;
        else if (c >= 61 && c <= 66)                 out_ready[i] = 1'b0;
        else                                         out_ready[i] = ($urandom_range(0, 9) < 7);
      end

      #1;
      for (int i = 0; i < 2; i++) begin
        exp_ov  = (wr[i] != rd[i]) && (q_rdy[i][rd[i] & 255] <= edge_cnt);
        exp_rdy = ((wr[i] - rd[i]) < stg(i)) || out_ready[i];
        check_val($sformatf("ready%0d_c%0d", i, c), {64'b0, rdy[i]}, {64'b0, exp_rdy});
        check_val($sformatf("ovalid%0d_c%0d", i, c), {64'b0, ov[i]}, {64'b0, exp_ov});
        if (exp_ov) begin
          front = q_val[i][rd[i] & 255];
          check_val($sformatf("imm%0d_c%0d", i, c), {1'b0, ext[i]}, {1'b0, front[63:0]});
`ifdef IMM_GEN_ERR_EN
          check_val($sformatf("err%0d_c%0d", i, c), {64'b0, er[i]}, {64'b0, front[64]});
`endif
        end
        acc = in_valid[i] & exp_rdy;
        drn = exp_ov & out_ready[i];
        pend[i] = in_valid[i] & ~exp_rdy;
        if (drn) rd[i]++;
        if (acc) begin
          q_val[i][wr[i] & 255] = cur_exp[i];
          q_rdy[i][wr[i] & 255] = edge_cnt + 1 + stg(i) - 1;
          wr[i]++;
          acc_cnt[i]++;
          if (is_dir[i]) diri[i]++;
        end
      end

      @(posedge clk);
      edge_cnt++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
